gearbox_pack: RTL and testbench
===============================

Name: gearbox_pack

Overview:
Narrow-to-wide packing gearbox. Accepts a stream of IN_WIDTH-bit words and concatenates them LSB-first into OUT_WIDTH-bit output words. It is the transmit-side counterpart of the wide-to-narrow unpacking gearbox. Supports frame termination (zero-padded partial final word) and output backpressure.

Parameters:
IN_WIDTH, 7, width of the narrow input stream; must be smaller than OUT_WIDTH
OUT_WIDTH, 32, width of the wide output stream; must be larger than IN_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  data_in/last_in valid this cycle
ready_in  output  1  block can accept a beat; transfer = valid_in && ready_in
data_in  input  IN_WIDTH  narrow input word
last_in  input  1  beat is final word of frame; flush after it
valid_out  output  1  data_out valid, held until accepted
ready_out  input  1  downstream accepts; transfer = valid_out && ready_out
data_out  output  OUT_WIDTH  packed wide word
valid_bits_out  output  $clog2(OUT_WIDTH+1)  number of meaningful LSBs in data_out
first_word  output  1  data_out is first word of a frame
last_word  output  1  data_out is final word of a frame

Behaviour:
- Storage: accumulator acc of width OUT_WIDTH+IN_WIDTH-1. Fill count cnt ranges 0..OUT_WIDTH-1 between words.
- Output register: data_out, valid_bits_out, first_word and last_word are registered and move only on load. All are stable while valid_out=1 && ready_out=0.
- Bit order is LSB-first. An accepted beat is placed at acc[cnt +: IN_WIDTH]. Earlier beats occupy lower bits.
- ready_in = !rst && state==FILL && (!valid_out || ready_out). It is combinational and has no input skid.
- FSM states: FILL, FLUSH.
- FILL, beat accepted, cnt+IN_WIDTH < OUT_WIDTH, last_in=0:
  - cnt += IN_WIDTH.
  - No output.
- FILL, beat accepted, cnt+IN_WIDTH >= OUT_WIDTH:
  - Load output with the low OUT_WIDTH bits; valid_bits_out = OUT_WIDTH.
  - Shift the residue down; cnt = cnt+IN_WIDTH-OUT_WIDTH.
  - If last_in=1 and residue > 0: go to FLUSH.
  - If last_in=1 and residue = 0: last_word=1, cnt=0.
- FILL, beat accepted, cnt+IN_WIDTH < OUT_WIDTH, last_in=1:
  - Load output with the partial word, zero-padded above bit cnt+IN_WIDTH-1.
  - valid_bits_out = cnt+IN_WIDTH; last_word=1.
  - cnt=0.
- FLUSH:
  - When the output register is free (!valid_out || ready_out), load the residue, zero-padded.
  - valid_bits_out = residue count; last_word=1; cnt=0.
  - Return to FILL.
  - ready_in=0 throughout FLUSH.
- Latency: valid_out rises the cycle after the completing beat (or the FLUSH load).
- Back-to-back operation: ready_out held at 1 sustains one beat per cycle with no bubbles, except the single FLUSH cycle.
- first_word:
  - Internal flag frame_start is set at reset and after any word loaded with last_word=1.
  - first_word = frame_start at load time; frame_start is cleared on that load.
  - A single-word frame has first_word=1 and last_word=1.
- Reset (rst=1 at clock edge), from any state including mid-frame or mid-FLUSH:
  - acc=0, cnt=0, state=FILL, frame_start=1.
  - valid_out=0, data_out=0, valid_bits_out=0, first_word=0, last_word=0.
  - The partial frame is discarded; ready_in=0 during reset.
- valid_in with ready_in=0 is ignored; the beat is not consumed.

Optional Feature:
Macro GEARBOX_PACK_OVERRUN_EN. Supports producers, such as the unpacking gearbox, that have no ready input.
- Defined:
  - Adds output port overrun_err (1 bit), sticky.
  - Set on the cycle after valid_in=1 && ready_in=0.
  - Cleared only by rst.
  - The dropped beat is not stored.
- Undefined: the port is absent and no logic is generated.

Test Plan:
1. IN=7/OUT=32, ready_out=1, 32 beats, no last_in -> 7 words, completed by beats 5,10,14,19,23,28,32; first_word only on word 0; valid_bits_out=32 on all.
2. Beats 0x01,0x02,0x03,0x04,0x05 -> data_out=0x5080C101, valid_bits_out=32, first_word=1; residual cnt=3 with value 0.
3. Three beats 0x7F, last_in on the third -> one word 0x001FFFFF, valid_bits_out=21, first_word=1, last_word=1.
4. Five beats, last_in on the fifth:
   - Word A: valid_bits_out=32, last_word=0.
   - ready_in=0 for one cycle (FLUSH).
   - Word B: valid_bits_out=3, last_word=1.
   - The next frame's first word has first_word=1.
5. ready_out=0 for 10 cycles while a word is pending -> ready_in=0; data_out, valid_bits_out and flags unchanged; after release, the stream resumes with no lost or duplicated beats.
6. rst asserted after 3 beats of a frame -> next cycle valid_out=0, all outputs 0; the next 5 beats produce a word with no stale bits and first_word=1. With GEARBOX_PACK_OVERRUN_EN, a beat during backpressure sets overrun_err=1 until rst.

Source files
------------

// File: rtl/gearbox_pack_if.sv
// Stream bundle for gearbox_pack: narrow input beats in, packed wide words out.
// Handshake: a beat/word moves on a rising edge where valid && ready are both 1; valid holds its payload until then.
interface gearbox_pack_if #(
    parameter int IN_WIDTH  = 7,
    parameter int OUT_WIDTH = 32
);
    localparam int VB_W = $clog2(OUT_WIDTH + 1);

    logic                 valid_in;
    logic                 ready_in;
    logic [IN_WIDTH-1:0]  data_in;
    logic                 last_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [OUT_WIDTH-1:0] data_out;
    logic [VB_W-1:0]      valid_bits_out;
    logic                 first_word;
    logic                 last_word;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, valid_bits_out, first_word, last_word
    );

    // Gearbox side
    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, valid_bits_out, first_word, last_word
    );
endinterface

// File: rtl/gearbox_pack.sv
// Narrow-to-wide packing gearbox: IN_WIDTH beats concatenated LSB-first into OUT_WIDTH words.
// Optional GEARBOX_PACK_OVERRUN_EN adds a sticky overrun_err flag for producers without backpressure.
module gearbox_pack #(
    parameter int IN_WIDTH  = 7,
    parameter int OUT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    gearbox_pack_if.slave    bus,
    output logic             o_dbg_state
`ifdef GEARBOX_PACK_OVERRUN_EN
    ,
    output logic             overrun_err
`endif
);
    localparam int ACC_W = OUT_WIDTH + IN_WIDTH - 1;
    localparam int SUM_W = $clog2(OUT_WIDTH + IN_WIDTH + 1);
    localparam int VB_W  = $clog2(OUT_WIDTH + 1);
    localparam logic [SUM_W-1:0] OUT_C = SUM_W'(OUT_WIDTH);
    localparam logic [SUM_W-1:0] IN_C  = SUM_W'(IN_WIDTH);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ACC_W-1:0]     r_acc;
    logic [SUM_W-1:0]     r_cnt;
    logic                 r_frame_start;

    logic                 r_valid_out;
    logic [OUT_WIDTH-1:0] r_data_out;
    logic [VB_W-1:0]      r_vbits;
    logic                 r_first;
    logic                 r_last;

    logic                 w_out_free;
    logic                 w_ready_in;
    logic                 w_take;
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     w_resid;
    logic                 w_full;
    logic [ACC_W-1:0]     w_merged;

    logic                 w_load;
    logic [OUT_WIDTH-1:0] w_ld_data;
    logic [VB_W-1:0]      w_ld_vbits;
    logic                 w_ld_first;
    logic                 w_ld_last;
    logic [ACC_W-1:0]     w_acc_nxt;
    logic [SUM_W-1:0]     w_cnt_nxt;
    logic                 w_fs_nxt;

    assign w_out_free = !r_valid_out || bus.ready_out;
    assign w_ready_in = !rst && (r_state == ST_FILL) && w_out_free;
    assign w_take     = bus.valid_in && w_ready_in;
    assign w_sum      = r_cnt + IN_C;
    assign w_resid    = w_sum - OUT_C;
    assign w_full     = (w_sum >= OUT_C);
    // Bits above r_cnt are always zero, so OR-ing the new beat in is a clean insert.
    assign w_merged   = r_acc | (ACC_W'(bus.data_in) << r_cnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: FLUSH is entered only when a frame ends with a residue left over after a full word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_take && w_full && bus.last_in && (w_resid != '0)) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // Output/datapath decode: what gets loaded into the output register and what stays in the accumulator.
    always_comb begin
        w_load     = 1'b0;
        w_ld_data  = r_data_out;
        w_ld_vbits = r_vbits;
        w_ld_first = r_first;
        w_ld_last  = r_last;
        w_acc_nxt  = r_acc;
        w_cnt_nxt  = r_cnt;
        w_fs_nxt   = r_frame_start;
        case (r_state)
            ST_FILL: begin
                if (w_take) begin
                    if (w_full) begin
                        w_load     = 1'b1;
                        w_ld_data  = w_merged[OUT_WIDTH-1:0];
                        w_ld_vbits = VB_W'(OUT_WIDTH);
                        w_ld_first = r_frame_start;
                        w_ld_last  = bus.last_in && (w_resid == '0);
                        w_acc_nxt  = w_merged >> OUT_WIDTH;
                        w_cnt_nxt  = w_resid;
                        w_fs_nxt   = bus.last_in && (w_resid == '0);
                    end else if (bus.last_in) begin
                        w_load     = 1'b1;
                        w_ld_data  = w_merged[OUT_WIDTH-1:0];
                        w_ld_vbits = VB_W'(w_sum);
                        w_ld_first = r_frame_start;
                        w_ld_last  = 1'b1;
                        w_acc_nxt  = '0;
                        w_cnt_nxt  = '0;
                        w_fs_nxt   = 1'b1;
                    end else begin
                        w_acc_nxt  = w_merged;
                        w_cnt_nxt  = w_sum;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_load     = 1'b1;
                    w_ld_data  = r_acc[OUT_WIDTH-1:0];
                    w_ld_vbits = VB_W'(r_cnt);
                    w_ld_first = r_frame_start;
                    w_ld_last  = 1'b1;
                    w_acc_nxt  = '0;
                    w_cnt_nxt  = '0;
                    w_fs_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_cnt         <= '0;
            r_frame_start <= 1'b1;
        end else begin
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    // Output register moves only on a load, so payload is frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_vbits     <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid_out <= 1'b1;
                r_data_out  <= w_ld_data;
                r_vbits     <= w_ld_vbits;
                r_first     <= w_ld_first;
                r_last      <= w_ld_last;
            end else if (bus.ready_out) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign bus.ready_in       = w_ready_in;
    assign bus.valid_out      = r_valid_out;
    assign bus.data_out       = r_data_out;
    assign bus.valid_bits_out = r_vbits;
    assign bus.first_word     = r_first;
    assign bus.last_word      = r_last;
    assign o_dbg_state        = r_state;

`ifdef GEARBOX_PACK_OVERRUN_EN
    logic r_overrun;

    // Sticky until reset; the refused beat is simply not stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (bus.valid_in && !w_ready_in) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun_err = r_overrun;
`endif

endmodule

// File: tb/tb_gearbox_pack.sv
// Directed and randomized bench for gearbox_pack against a bit-queue reference model.
module tb_gearbox_pack;
    localparam int IN_W  = 7;
    localparam int OUT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;
`ifdef GEARBOX_PACK_OVERRUN_EN
    logic ovr;
    logic exp_ovr = 1'b0;
`endif

    always #5 clk = ~clk;

    gearbox_pack_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

    gearbox_pack #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
`ifdef GEARBOX_PACK_OVERRUN_EN
        ,
        .overrun_err (ovr)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] exp_q[$];
    int               exp_vb_q[$];
    bit               exp_first_q[$];
    bit               exp_last_q[$];
    bit               model_bits[$];
    bit               model_fs = 1'b1;
    bit               flush_pending = 1'b0;
    bit               accepted;
    int               beats_acc = 0;
    bit               t1_mode = 1'b0;
    int               t1_idx = 0;
    int               t1_beats[7] = '{5, 10, 14, 19, 23, 28, 32};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [OUT_W-1:0] w, input int n, input bit f, input bit l);
        exp_q.push_back(w);
        exp_vb_q.push_back(n);
        exp_first_q.push_back(f);
        exp_last_q.push_back(l);
    endtask

    // Reference: a flat bit stream chopped into OUT_W words; frame end emits the leftover bits.
    task automatic model_accept(input logic [IN_W-1:0] d, input logic l);
        int nfull;
        int n;
        logic [OUT_W-1:0] w;
        nfull = 0;
        for (int i = 0; i < IN_W; i++) model_bits.push_back(d[i]);
        while (model_bits.size() >= OUT_W) begin
            w = '0;
            for (int i = 0; i < OUT_W; i++) w[i] = model_bits.pop_front();
            push_exp(w, OUT_W, model_fs, 1'b0);
            model_fs = 1'b0;
            nfull++;
        end
        if (l) begin
            n = model_bits.size();
            if (n > 0) begin
                w = '0;
                for (int i = 0; i < n; i++) w[i] = model_bits.pop_front();
                push_exp(w, n, model_fs, 1'b1);
                if (nfull > 0) flush_pending = 1'b1;
            end else begin
                exp_last_q[exp_last_q.size()-1] = 1'b1;
            end
            model_fs = 1'b1;
        end
    endtask

    task automatic cycle();
        logic exp_ready;
        @(negedge clk);
        exp_ready = !rst && !flush_pending && (!bus.valid_out || bus.ready_out);
        chk("ready_in", bus.ready_in, exp_ready);
`ifdef GEARBOX_PACK_OVERRUN_EN
        chk("overrun_err", ovr, exp_ovr);
        exp_ovr = rst ? 1'b0 : (exp_ovr | (bus.valid_in && !bus.ready_in));
`endif
        if (bus.valid_out && bus.ready_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", bus.valid_out, 1'b0);
            end else begin
                chk("data_out", bus.data_out, exp_q.pop_front());
                chk("valid_bits_out", bus.valid_bits_out, exp_vb_q.pop_front());
                chk("first_word", bus.first_word, exp_first_q.pop_front());
                chk("last_word", bus.last_word, exp_last_q.pop_front());
                if (t1_mode) begin
                    if (t1_idx < 7) chk("t1_completing_beat", beats_acc, t1_beats[t1_idx]);
                    else chk("t1_extra_word", bus.valid_out, 1'b0);
                    t1_idx++;
                end
            end
        end
        accepted = bus.valid_in && bus.ready_in;
        if (accepted) begin
            model_accept(bus.data_in, bus.last_in);
            beats_acc++;
        end else if (flush_pending && (!bus.valid_out || bus.ready_out)) begin
            flush_pending = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic l);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.last_in  = l;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) chk("send_timeout", accepted, 1'b1);
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_in  = 1'b0;
        bus.last_in   = 1'b0;
        bus.ready_out = 1'b0;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        exp_vb_q.delete();
        exp_first_q.delete();
        exp_last_q.delete();
        model_bits.delete();
        model_fs      = 1'b1;
        flush_pending = 1'b0;
        chk("rst_valid_out", bus.valid_out, 1'b0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_valid_bits", bus.valid_bits_out, 0);
        chk("rst_first_word", bus.first_word, 1'b0);
        chk("rst_last_word", bus.last_word, 1'b0);
        chk("rst_state", dbg_state, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.last_in   = 1'b0;
        bus.ready_out = 1'b0;
        do_reset();

        // Continuous stream, no frame end: 7 full words at fixed completing beats
        bus.ready_out = 1'b1;
        t1_mode   = 1'b1;
        t1_idx    = 0;
        beats_acc = 0;
        for (int i = 0; i < 32; i++) send(IN_W'($urandom), 1'b0);
        idle(3);
        t1_mode = 1'b0;
        chk("t1_word_count", t1_idx, 7);

        // Known pattern 1..5 and the zero residue it leaves
        do_reset();
        bus.ready_out = 1'b1;
        for (int i = 1; i <= 5; i++) send(IN_W'(i), 1'b0);
        chk("t2_data", bus.data_out, 32'h5080C101);
        chk("t2_vbits", bus.valid_bits_out, 32);
        chk("t2_first", bus.first_word, 1'b1);
        send(7'h7F, 1'b1);
        chk("t2_residue_data", bus.data_out, 32'h0000_03F8);
        chk("t2_residue_vbits", bus.valid_bits_out, 10);
        idle(2);

        // Short single-word frame
        do_reset();
        bus.ready_out = 1'b1;
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b1);
        chk("t3_data", bus.data_out, 32'h001F_FFFF);
        chk("t3_vbits", bus.valid_bits_out, 21);
        chk("t3_first", bus.first_word, 1'b1);
        chk("t3_last", bus.last_word, 1'b1);
        idle(2);

        // Frame ending with a residue: full word, one FLUSH cycle, 3-bit tail
        for (int i = 0; i < 5; i++) send(IN_W'($urandom), i == 4);
        chk("t4_a_vbits", bus.valid_bits_out, 32);
        chk("t4_a_last", bus.last_word, 1'b0);
        chk("t4_flush_ready", bus.ready_in, 1'b0);
        chk("t4_flush_state", dbg_state, 1'b1);
        idle(1);
        chk("t4_b_vbits", bus.valid_bits_out, 3);
        chk("t4_b_last", bus.last_word, 1'b1);
        chk("t4_b_first", bus.first_word, 1'b0);
        for (int i = 0; i < 5; i++) send(IN_W'($urandom), 1'b0);
        chk("t4_next_first", bus.first_word, 1'b1);
        idle(2);

        // Backpressure: word held stable for 10 cycles while a beat waits
        do_reset();
        for (int i = 0; i < 5; i++) send(IN_W'($urandom), 1'b0);
        bus.valid_in = 1'b1;
        bus.data_in  = IN_W'($urandom);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t5_hold_valid", bus.valid_out, 1'b1);
            chk("t5_hold_data", bus.data_out, exp_q[0]);
            chk("t5_hold_vbits", bus.valid_bits_out, exp_vb_q[0]);
            chk("t5_hold_first", bus.first_word, exp_first_q[0]);
        end
`ifdef GEARBOX_PACK_OVERRUN_EN
        chk("t5_overrun_set", ovr, 1'b1);
`endif
        bus.ready_out = 1'b1;
        for (int i = 0; i < 10; i++) send(IN_W'($urandom), i == 9);
        idle(3);

        // Reset in the middle of a frame discards it
        do_reset();
`ifdef GEARBOX_PACK_OVERRUN_EN
        chk("t6_overrun_clear", ovr, 1'b0);
`endif
        bus.ready_out = 1'b1;
        for (int i = 0; i < 3; i++) send(7'h7F, 1'b0);
        do_reset();
        bus.ready_out = 1'b1;
        for (int i = 0; i < 5; i++) send(7'h00, 1'b0);
        chk("t6_no_stale", bus.data_out, 0);
        chk("t6_first", bus.first_word, 1'b1);
        idle(2);

        // Randomized traffic with random backpressure and frame ends
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            bus.valid_in  = ($urandom_range(0, 3) != 0);
            bus.data_in   = IN_W'($urandom);
            bus.last_in   = ($urandom_range(0, 9) == 0);
            bus.ready_out = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.ready_out = 1'b1;
        idle(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
